// File: rtl/scpad_types_pkg.sv
// Shared scratchpad types: requester ids, in-flight read tag, lane geometry.
package scpad_types_pkg;

  localparam int NUM_COLS = 32;
  localparam int ELEM_W   = 16;
  localparam int NUM_REQ  = 3;

  typedef enum logic [1:0] {
    FRONTEND_VC_REQ = 2'd0,
    FRONTEND_SA_REQ = 2'd1,
    BACKEND_REQ     = 2'd2
  } int_id_e;

  typedef struct packed {
    logic                valid;
    int_id_e             int_id;
    logic [NUM_COLS-1:0] mask;
  } inflight_tag_t;

  // (a + b) mod 3 for requester ids; both operands are in 0..2.
  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/scpad_tag_fifo.sv
// In-flight tag FIFO; push and pop may coincide, including when full.
module scpad_tag_fifo
  import scpad_types_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  inflight_tag_t push_tag,
  input  logic          pop,
  output inflight_tag_t head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  inflight_tag_t mem_q [DEPTH];
  inflight_tag_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_q];
  // A pop frees the head slot this cycle, so a push at full is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) mem_d[wr_q] = push_tag;
  end

  // State registers; reset empties the FIFO and forgets all tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/scpad_read_arbiter.sv
// Round-robin read arbiter onto the SRAM read port with in-order tag return.
module scpad_read_arbiter
  import scpad_types_pkg::*;
#(
  parameter  int DESC_W         = 96,
  parameter  int SCPAD_ID_WIDTH = 1,
  parameter  int TAG_DEPTH      = 4,
  localparam int DATA_W         = NUM_COLS * ELEM_W,
  localparam int CNT_W          = $clog2(TAG_DEPTH) + 1
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DESC_W-1:0]         req_desc,
  input  logic [NUM_REQ*SCPAD_ID_WIDTH-1:0] req_scpad_id,
  input  logic [NUM_REQ*NUM_COLS-1:0]       req_mask,
  output logic                              sram_req_valid,
  output logic [1:0]                        sram_req_int_id,
  output logic [DESC_W-1:0]                 sram_req_desc,
  output logic [SCPAD_ID_WIDTH-1:0]         sram_req_scpad_id,
  input  logic                              sram_busy,
  input  logic                              sram_res_valid,
  input  logic [DATA_W-1:0]                 sram_res_rdata,
  output logic [NUM_REQ-1:0]                res_valid,
  output logic [DATA_W-1:0]                 res_rdata,
  output logic                              sram_busy_out,
  output logic                              err_orphan
);

  logic [NUM_REQ-1:0][DESC_W-1:0]         desc_arr;
  logic [NUM_REQ-1:0][SCPAD_ID_WIDTH-1:0] sid_arr;
  logic [NUM_REQ-1:0][NUM_COLS-1:0]       mask_arr;
  logic [NUM_COLS-1:0][ELEM_W-1:0]        rdata_arr, masked_arr;

  assign desc_arr  = req_desc;
  assign sid_arr   = req_scpad_id;
  assign mask_arr  = req_mask;
  assign rdata_arr = sram_res_rdata;

  logic [1:0]          rr_ptr_q, rr_ptr_d, gnt_id, cand;
  logic                gnt_found, gnt_valid, can_issue;
  logic                tag_full, tag_empty, tag_pop, orphan;
  logic [CNT_W-1:0]    tag_count;
  inflight_tag_t       push_tag, tag_head;

  logic                sram_req_valid_q, sram_req_valid_d;
  logic [1:0]          sram_req_int_id_q, sram_req_int_id_d;
  logic [DESC_W-1:0]   sram_req_desc_q, sram_req_desc_d;
  logic [SCPAD_ID_WIDTH-1:0] sram_req_sid_q, sram_req_sid_d;
  logic [NUM_REQ-1:0]  res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_rdata_q, res_rdata_d;
  logic                err_q, err_d;

  // A returning read frees a tag slot in the same cycle, so a full FIFO can still issue.
  assign can_issue = !sram_busy && (!tag_full || sram_res_valid);
  assign tag_pop   = sram_res_valid && !tag_empty && tag_head.valid;
  assign orphan    = sram_res_valid && !tag_pop;

  // Round-robin pick: first asserted requester at or after the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = add_mod3(rr_ptr_q, 2'(k));
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    gnt_valid = gnt_found && can_issue;
    req_ready = gnt_valid ? (3'b001 << gnt_id) : '0;
    rr_ptr_d  = gnt_valid ? add_mod3(gnt_id, 2'd1) : rr_ptr_q;
  end

  assign push_tag = '{valid: 1'b1, int_id: int_id_e'(gnt_id), mask: mask_arr[gnt_id]};

  scpad_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .push     (gnt_valid),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  // Per-lane column mask on the returning row.
  for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
    assign masked_arr[i] = tag_head.mask[i] ? rdata_arr[i] : '0;
  end

  // Forwarded request fields load only on a grant; valid drops without one.
  always_comb begin
    sram_req_valid_d  = gnt_valid;
    sram_req_int_id_d = sram_req_int_id_q;
    sram_req_desc_d   = sram_req_desc_q;
    sram_req_sid_d    = sram_req_sid_q;
    if (gnt_valid) begin
      sram_req_int_id_d = gnt_id;
      sram_req_desc_d   = desc_arr[gnt_id];
      sram_req_sid_d    = sid_arr[gnt_id];
    end
  end

  // Response routing to the head tag's requester; orphans only raise the sticky flag.
  always_comb begin
    res_valid_d = '0;
    res_rdata_d = res_rdata_q;
    err_d       = err_q | orphan;
    if (tag_pop) begin
      res_valid_d = 3'b001 << tag_head.int_id;
      res_rdata_d = masked_arr;
    end
  end

  // Arbiter and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q          <= FRONTEND_VC_REQ;
      sram_req_valid_q  <= 1'b0;
      sram_req_int_id_q <= '0;
      sram_req_desc_q   <= '0;
      sram_req_sid_q    <= '0;
      res_valid_q       <= '0;
      res_rdata_q       <= '0;
      err_q             <= 1'b0;
    end else begin
      rr_ptr_q          <= rr_ptr_d;
      sram_req_valid_q  <= sram_req_valid_d;
      sram_req_int_id_q <= sram_req_int_id_d;
      sram_req_desc_q   <= sram_req_desc_d;
      sram_req_sid_q    <= sram_req_sid_d;
      res_valid_q       <= res_valid_d;
      res_rdata_q       <= res_rdata_d;
      err_q             <= err_d;
    end
  end

  assign sram_req_valid    = sram_req_valid_q;
  assign sram_req_int_id   = sram_req_int_id_q;
  assign sram_req_desc     = sram_req_desc_q;
  assign sram_req_scpad_id = sram_req_sid_q;
  assign res_valid         = res_valid_q;
  assign res_rdata         = res_rdata_q;
  assign err_orphan        = err_q;
  assign sram_busy_out     = (tag_count == CNT_W'(TAG_DEPTH));

endmodule

// File: doc/scpad_read_arbiter.md
Name: scpad_read_arbiter

Overview:
Arbitrates scratchpad read requests from the VC frontend, SA frontend and backend onto the single SRAM-control read port. It tracks each in-flight read in a tag FIFO and routes the returning bank data back to the originating requester, applying that requester's column mask. It sits directly upstream of the SRAM controller read path and downstream of the frontend_vc, frontend_sa and backend request generators.

Parameters:
NUM_COLS, 32, columns per scratchpad row; one lane per column
ELEM_W, 16, bits per column element; data width DATA_W = NUM_COLS*ELEM_W
DESC_W, 96, width of the packed xbar descriptor (slot/shift/valid masks); opaque to this block
SCPAD_ID_WIDTH, 1, scratchpad select width
TAG_DEPTH, 4, maximum in-flight reads (power of 2, ≥2)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
req_valid  in  3  per-requester request valid; bit0=VC, bit1=SA, bit2=BACKEND (matches int_id encoding 00/01/10)
req_ready  out  3  per-requester accept; handshake occurs when valid&ready
req_desc  in  3*DESC_W  per-requester xbar descriptor
req_scpad_id  in  3*SCPAD_ID_WIDTH  per-requester scratchpad select
req_mask  in  3*NUM_COLS  per-requester column-enable mask for the response
sram_req_valid  out  1  read request to SRAM control
sram_req_int_id  out  2  originating requester id
sram_req_desc  out  DESC_W  forwarded descriptor
sram_req_scpad_id  out  SCPAD_ID_WIDTH  forwarded scratchpad select
sram_busy  in  1  SRAM control cannot take a request this cycle
sram_res_valid  in  1  read data return (in-order)
sram_res_rdata  in  DATA_W  returned row data
res_valid  out  3  per-requester response valid (one-hot or zero)
res_rdata  out  DATA_W  masked response data, shared bus
sram_busy_out  out  1  backpressure to frontends: tag FIFO full
err_orphan  out  1  sticky: a response arrived with no tag outstanding

Behaviour:
- Reset (async, nRST=0): all outputs 0; tag FIFO empty; round-robin pointer = VC; err_orphan cleared. A reset mid-operation discards all in-flight tags; later SRAM returns are treated as orphans.
- can_issue = !sram_busy && (tag_count < TAG_DEPTH || sram_res_valid). A pop and a push in the same cycle at full is legal.
- Arbitration is round-robin over the asserted req_valid bits, starting at the pointer. The pointer moves to (granted+1) mod 3 after each grant and is unchanged when there is no grant. req_ready is the one-hot grant, asserted only when can_issue; it is combinational from req_valid.
- Grant is registered: sram_req_* is valid 1 cycle after the handshake. sram_req_valid deasserts the next cycle if there is no new grant. At most one request is issued per cycle, giving throughput 1/cycle.
- The push happens on the grant cycle and stores {int_id, req_mask of the granted requester}.
- On sram_res_valid: pop the head tag. Registered response: res_valid[head.int_id]=1 and res_rdata = sram_res_rdata with lane i zeroed where mask[i]=0, both 1 cycle later.
- If sram_res_valid arrives with the FIFO empty (and no same-cycle push from an earlier cycle): drop the data, set err_orphan (held until reset), and keep res_valid at 0.
- Responses return in issue order; there is no reordering.
- sram_busy_out = (tag_count == TAG_DEPTH), registered-count based.
- tag_count is clog2(TAG_DEPTH)+1 bits wide; read/write pointers wrap at TAG_DEPTH.

Decomposition:
- Shared package scpad_types_pkg holds:
  - the interaction-id enum (FRONTEND_VC_REQ=0, FRONTEND_SA_REQ=1, BACKEND_REQ=2)
  - the inflight tag struct {valid, int_id, mask[NUM_COLS]}
  - the NUM_COLS and ELEM_W constants
- Sub-module scpad_tag_fifo: a generic synchronous FIFO of inflight tags with push, pop, full, empty and count outputs, supporting simultaneous push+pop at full.

Test Plan:
- Single VC read with mask 0xFFFF_FFFF and SRAM returning data 0xA5 repeated: req_ready[0] on the request cycle; sram_req_valid with int_id=0 at +1; res_valid=3'b001 with unmasked data 1 cycle after sram_res_valid.
- All three requesters held valid for 6 cycles with sram_busy=0 and responses returned promptly: grant order VC,SA,BE,VC,SA,BE; res_valid order matches.
- Only SA and BACKEND valid, pointer at VC: SA is granted first, then BE, then SA.
- TAG_DEPTH=4 with responses withheld: 4 grants, then req_ready=0 and sram_busy_out=1. In the cycle sram_res_valid arrives with a pending request, a grant issues and the count stays at 4.
- Mask 0x0000_000F on a BACKEND read with data all 0xFFFF: res_rdata has only lanes 0-3 = 0xFFFF, all other lanes 0.
- Two requests outstanding, nRST pulsed low, then two sram_res_valid: no res_valid asserted, and err_orphan=1 after the first orphan.
